// File: rtl/dns_operand_loader.sv
// dns_operand_loader
// Upstream stage of the DNS 4x4 matrix multiplier. Collects a byte stream
// (matrix A row-major, then matrix B row-major) into one of two banks and
// presents completed A/B pairs to the multiplier. One bank loads while the
// other is being consumed.

module dns_operand_loader #(
   parameter int DW = 8,
   parameter int N  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW-1:0]       in_data,
   input  logic                in_last,
   output logic                mat_valid,
   input  logic                mat_ready,
   output logic [N*N*DW-1:0]   a_flat,
   output logic [N*N*DW-1:0]   b_flat,
   output logic [1:0]          banks_full,
   output logic                frame_err
);

   localparam int NN    = N * N;
   localparam int FRAME = 2 * NN;
   localparam int CW    = $clog2(FRAME);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

   // Frame position and bank bookkeeping
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wbank_q, wbank_d;
   logic          rbank_q, rbank_d;
   logic [1:0]    full_q, full_d;
   logic          frameErr_q, frameErr_d;

   // Bank storage, one packed row per bank; never reset
   logic [1:0][NN*DW-1:0] aMem_q;
   logic [1:0][NN*DW-1:0] bMem_q;

   logic accept;
   logic handoff;

   // A bank that is full cannot be written, so a full write bank stalls the
   // stream. Both handshake outputs are forced low while reset is asserted.
   assign in_ready   = !rst && !full_q[wbank_q];
   assign mat_valid  = !rst && full_q[rbank_q];
   assign accept     = in_valid && in_ready;
   assign handoff    = mat_valid && mat_ready;

   assign a_flat     = aMem_q[rbank_q];
   assign b_flat     = bMem_q[rbank_q];
   assign banks_full = full_q;
   assign frame_err  = frameErr_q;

   // Next-state: release of the read bank and commit/abandon of the write bank.
   // Release and commit always touch different banks, because the write bank
   // cannot accept while it is full.
   always_comb begin
      cnt_d      = cnt_q;
      wbank_d    = wbank_q;
      rbank_d    = rbank_q;
      full_d     = full_q;
      frameErr_d = 1'b0;

      if (handoff) begin
         full_d[rbank_q] = 1'b0;
         rbank_d         = ~rbank_q;
      end

      if (accept) begin
         if (cnt_q == LAST_IDX) begin
            cnt_d           = '0;
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
            frameErr_d      = !in_last;
         end else if (in_last) begin
            cnt_d      = '0;
            frameErr_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Control registers with synchronous reset; storage is left untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         full_q     <= 2'b00;
         frameErr_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         wbank_q    <= wbank_d;
         rbank_q    <= rbank_d;
         full_q     <= full_d;
         frameErr_q <= frameErr_d;
      end
   end

   // Element write: stream index k lands at element slot k of A (k < NN)
   // or slot k-NN of B, which matches the row-major flat packing directly
   always_ff @(posedge clk) begin
      for (int e = 0; e < NN; e++) begin
         if (accept && cnt_q == CW'(e)) begin
            aMem_q[wbank_q][e*DW +: DW] <= in_data;
         end
         if (accept && cnt_q == CW'(NN + e)) begin
            bMem_q[wbank_q][e*DW +: DW] <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_dns_operand_loader.sv
// tb_dns_operand_loader
// Self-checking bench for dns_operand_loader. A reference model keeps the
// partially received frame as a byte queue and the completed frames as a
// FIFO of packed 256-bit frames; the DUT must present them in order.

module tb_dns_operand_loader;

   localparam int DW    = 8;
   localparam int N     = 4;
   localparam int NN    = N * N;
   localparam int FRAME = 2 * NN;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data   = '0;
   logic          in_last   = 1'b0;
   logic          mat_valid;
   logic          mat_ready = 1'b0;
   logic [NN*DW-1:0] a_flat;
   logic [NN*DW-1:0] b_flat;
   logic [1:0]    banks_full;
   logic          frame_err;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state
   logic [2*NN*DW-1:0] pendQ[$];
   logic [DW-1:0]      curBeats[$];
   logic               expErr = 1'b0;

   // Free-running clock
   always #5 clk = ~clk;

   dns_operand_loader #(.DW(DW), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .mat_valid  (mat_valid),
      .mat_ready  (mat_ready),
      .a_flat     (a_flat),
      .b_flat     (b_flat),
      .banks_full (banks_full),
      .frame_err  (frame_err)
   );

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string tag, input logic [2*NN*DW-1:0] obs,
                             input logic [2*NN*DW-1:0] expv);
      testsRun++;
      assert (obs === expv) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Compare DUT outputs against the model's view of occupancy and data
   task automatic checkOutput();
      checkValue("in_ready", in_ready, pendQ.size() < 2);
      checkValue("mat_valid", mat_valid, pendQ.size() > 0);
      checkValue("frame_err", frame_err, expErr);
      checkValue("banks_full_count", $countones(banks_full), pendQ.size());
      if (pendQ.size() > 0) begin
         checkValue("a_flat", a_flat, pendQ[0][NN*DW-1:0]);
         checkValue("b_flat", b_flat, pendQ[0][2*NN*DW-1:NN*DW]);
      end
   endtask

   // One clock cycle: check at the falling edge, drive inputs, advance the
   // model by what the coming rising edge should do, then wait for that edge
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l,
                                input logic r, output logic acc);
      logic [2*NN*DW-1:0] f;
      @(negedge clk);
      checkOutput();
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      mat_ready = r;
      acc    = v && (pendQ.size() < 2);
      expErr = 1'b0;
      if (r && pendQ.size() > 0) pendQ.delete(0);
      if (acc) begin
         curBeats.push_back(d);
         if (curBeats.size() == FRAME) begin
            f = '0;
            foreach (curBeats[k]) f[k*DW +: DW] = curBeats[k];
            pendQ.push_back(f);
            expErr = !l;
            curBeats.delete();
         end else if (l) begin
            curBeats.delete();
            expErr = 1'b1;
         end
      end
      @(posedge clk);
   endtask

   // Stream nBeats elements of f; in_last set on beat lastAt (-1 for never)
   task automatic sendBeats(input logic [2*NN*DW-1:0] f, input int nBeats, input int lastAt,
                            input logic r, input logic rLast);
      int   beat   = 0;
      int   budget = 0;
      logic acc;
      while (beat < nBeats) begin
         applyStimulus(1'b1, f[beat*DW +: DW], beat == lastAt,
                       (beat == nBeats - 1) ? rLast : r, acc);
         if (acc) beat++;
         budget++;
         if (budget > 200) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL send_timeout: observed beat %0d expected %0d beats", beat, nBeats);
            break;
         end
      end
   endtask

   task automatic idle(input int n, input logic r);
      logic acc;
      repeat (n) applyStimulus(1'b0, DW'($urandom), 1'b0, r, acc);
   endtask

   // Synchronous reset for one edge, checking the handshake outputs stay low
   task automatic doReset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      mat_ready = 1'b0;
      #1;
      checkValue("rst_in_ready", in_ready, 1'b0);
      checkValue("rst_mat_valid", mat_valid, 1'b0);
      pendQ.delete();
      curBeats.delete();
      expErr = 1'b0;
      @(posedge clk);
      #1;
      checkValue("rst_banks_full", banks_full, 2'b00);
      checkValue("rst_frame_err", frame_err, 1'b0);
      checkValue("rst_mat_valid_held", mat_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkValue("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
   endtask

   function automatic logic [2*NN*DW-1:0] randFrame();
      logic [2*NN*DW-1:0] f;
      for (int k = 0; k < FRAME; k++) f[k*DW +: DW] = DW'($urandom);
      return f;
   endfunction

   // Directed scenarios followed by a randomized stretch
   initial begin
      logic [2*NN*DW-1:0] f1, f2, f3;
      logic acc;

      doReset();

      // Single frame: element k carries k+1, so A is 1..16 and B is 17..32
      for (int k = 0; k < FRAME; k++) f1[k*DW +: DW] = DW'(k + 1);
      sendBeats(f1, 32, 31, 1'b1, 1'b1);
      #1;
      checkValue("t1_mat_valid", mat_valid, 1'b1);
      checkValue("t1_a00", a_flat[7:0], 8'd1);
      checkValue("t1_a33", a_flat[127:120], 8'd16);
      checkValue("t1_b00", b_flat[7:0], 8'd17);
      checkValue("t1_b33", b_flat[127:120], 8'd32);
      checkValue("t1_frame_err", frame_err, 1'b0);
      idle(3, 1'b1);

      // Backpressure: two frames fill both banks, third waits for a release
      doReset();
      f1 = randFrame();
      f2 = randFrame();
      f3 = randFrame();
      sendBeats(f1, 32, 31, 1'b0, 1'b0);
      sendBeats(f2, 32, 31, 1'b0, 1'b0);
      #1;
      checkValue("t2_both_full", banks_full, 2'b11);
      checkValue("t2_stalled", in_ready, 1'b0);
      applyStimulus(1'b1, f3[7:0], 1'b0, 1'b1, acc);
      #1;
      checkValue("t2_ready_after_release", in_ready, 1'b1);
      checkValue("t2_bank1_left", banks_full, 2'b10);
      checkValue("t2_frame2_shown", a_flat, f2[NN*DW-1:0]);
      sendBeats(f3, 32, 31, 1'b0, 1'b0);
      #1;
      checkValue("t2_full_again", banks_full, 2'b11);
      idle(4, 1'b1);

      // Early in_last on beat 10 abandons the partial frame
      doReset();
      f1 = randFrame();
      f2 = randFrame();
      sendBeats(f1, 11, 10, 1'b0, 1'b0);
      #1;
      checkValue("t3_frame_err", frame_err, 1'b1);
      checkValue("t3_no_valid", mat_valid, 1'b0);
      sendBeats(f2, 32, 31, 1'b0, 1'b0);
      #1;
      checkValue("t3_bank0", banks_full, 2'b01);
      checkValue("t3_b_flat", b_flat, f2[2*NN*DW-1:NN*DW]);
      idle(3, 1'b1);

      // Missing in_last: error pulse but the frame is still committed
      doReset();
      f1 = randFrame();
      sendBeats(f1, 32, -1, 1'b0, 1'b0);
      #1;
      checkValue("t4_frame_err", frame_err, 1'b1);
      checkValue("t4_mat_valid", mat_valid, 1'b1);
      checkValue("t4_a_flat", a_flat, f1[NN*DW-1:0]);
      idle(2, 1'b0);
      idle(2, 1'b1);

      // Completion into bank 1 on the same edge bank 0 is released
      doReset();
      f1 = randFrame();
      f2 = randFrame();
      sendBeats(f1, 32, 31, 1'b0, 1'b0);
      sendBeats(f2, 32, 31, 1'b0, 1'b1);
      #1;
      checkValue("t5_banks", banks_full, 2'b10);
      checkValue("t5_mat_valid", mat_valid, 1'b1);
      checkValue("t5_a_flat", a_flat, f2[NN*DW-1:0]);
      checkValue("t5_b_flat", b_flat, f2[2*NN*DW-1:NN*DW]);
      idle(2, 1'b1);

      // Reset mid-frame with a frame pending discards everything
      doReset();
      f1 = randFrame();
      f2 = randFrame();
      f3 = randFrame();
      sendBeats(f1, 32, 31, 1'b0, 1'b0);
      sendBeats(f2, 20, -1, 1'b0, 1'b0);
      doReset();
      idle(2, 1'b1);
      sendBeats(f3, 32, 31, 1'b0, 1'b0);
      #1;
      checkValue("t6_banks", banks_full, 2'b01);
      checkValue("t6_a_flat", a_flat, f3[NN*DW-1:0]);
      idle(2, 1'b1);

      // Randomized traffic: sporadic valid, ready, and framing errors
      doReset();
      for (int c = 0; c < 600; c++) begin
         logic v, l, r;
         v = ($urandom % 4) != 0;
         r = ($urandom % 3) != 0;
         if (curBeats.size() == FRAME - 1) l = ($urandom % 8) != 0;
         else                              l = ($urandom % 40) == 0;
         applyStimulus(v, DW'($urandom), l, r, acc);
      end
      idle(6, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dns_operand_loader.md
Name: dns_operand_loader

Overview:
- Upstream stage of the DNS 4x4 matrix multiplier.
- Accepts a byte stream of operand elements over a valid/ready handshake: matrix A row-major, then matrix B row-major, as one frame.
- Assembles each frame into full parallel A and B matrices and presents them to the multiplier with a valid/ready handshake.
- Ping-pong double buffer: the next frame loads while the multiplier consumes the current one.

Parameters:
- DW, 8, element width in bits.
- N, 4, matrix dimension. Frame length is 2*N*N elements; the multiplier requires N=4.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  stream element valid.
- in_ready  output  1  loader can accept an element this cycle.
- in_data  input  DW  element value.
- in_last  input  1  marks the final element (index 2*N*N-1) of a frame.
- mat_valid  output  1  complete A/B pair available on a_flat/b_flat.
- mat_ready  input  1  multiplier accepts the presented pair.
- a_flat  output  N*N*DW  matrix A; element (i,j) at bits [(N*i+j)*DW +: DW].
- b_flat  output  N*N*DW  matrix B; same packing.
- banks_full  output  2  per-bank full flags, for debug and occupancy.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset is synchronous (rst sampled on clk rising edge). It clears:
  - cnt=0, wbank=0, rbank=0, banks_full=2'b00, frame_err=0.
  - Bank storage is not cleared; its contents are don't-care until written.
  - in_ready=0 and mat_valid=0 while rst is high.
- State per bank: full flag. Global state:
  - wbank, the write bank.
  - rbank, the read bank.
  - cnt, 0..2*N*N-1, the element index within the current frame.
- in_ready = !rst && !banks_full[wbank] (combinational).
- Accept = in_valid && in_ready. On accept:
  - cnt < N*N: write A[cnt/N][cnt%N] of bank wbank.
  - Otherwise: write B[(cnt-N*N)/N][(cnt-N*N)%N] of bank wbank.
  - cnt increments.
- Frame completion: accept with cnt == 2*N*N-1 causes:
  - cnt<=0, banks_full[wbank]<=1, wbank toggles.
  - If in_last==0 on that element: frame_err pulses for 1 cycle. The frame is still committed.
- Early in_last: accept with in_last==1 and cnt != 2*N*N-1 causes:
  - Element is written, then discarded.
  - cnt<=0; bank stays not-full and wbank is unchanged, so the partial frame is abandoned.
  - frame_err pulses for 1 cycle.
- Output side:
  - mat_valid = banks_full[rbank].
  - a_flat/b_flat = contents of bank rbank (mux, no added latency).
  - Outputs are stable while mat_valid && !mat_ready.
- Release: mat_valid && mat_ready causes banks_full[rbank]<=0 and rbank toggles.
- Latency: last element accepted in cycle t → mat_valid high in cycle t+1.
- Throughput: with mat_ready held high, one frame per 2*N*N cycles, with no input stalls.
- Simultaneous completion into one bank and release of the other bank in the same cycle: both take effect.
- Same-bank conflict is impossible, because in_ready=0 whenever the write bank is full.
- Both banks full: in_ready=0 until a release. in_ready rises in the cycle after the release edge.
- Reset mid-frame: the partial frame is dropped and any full banks are discarded. No mat_valid until a new full frame arrives.
- in_data is ignored when no accept occurs. in_last is only meaningful on accept.

Test Plan:
1. Single frame: A[i][j]=4i+j+1, B[i][j]=16+4i+j+1, 32 back-to-back beats with in_last on beat 31, mat_ready=1 → mat_valid high exactly 1 cycle after beat 31. a_flat[7:0]=1, a_flat[127:120]=16, b_flat[7:0]=17, b_flat[127:120]=32. frame_err never pulses.
2. Backpressure: mat_ready=0, stream 3 frames → in_ready drops after beat 63 and banks_full=2'b11. Raise mat_ready for 1 cycle → frame 1 released, in_ready=1 next cycle, frame 3 completes. Frames 2 and 3 are then presented in order with the correct data.
3. Early in_last on beat 10 → frame_err one-cycle pulse, no mat_valid. A following correct 32-beat frame is presented intact, in bank 0.
4. Missing in_last on beat 31 → frame_err one-cycle pulse, frame still presented with correct data.
5. Simultaneous events: bank 0 full and presented, with mat_ready asserted on the same cycle bank 1's beat 31 is accepted → banks_full goes 01→10, and mat_valid stays high showing bank 1 data next cycle.
6. Reset at beat 20 of frame 2 while frame 1 is pending → mat_valid=0, in_ready=0 during rst. After reset, banks_full=0 and a fresh frame completes with correct data.
